// File: rtl/mvb_frame_tx.sv
// MVB frame transmitter: FIFO-buffered words sent as a Manchester-coded frame
// (start delimiter, data words, CRC-8, end delimiter) followed by an idle gap.
// state | meaning
// IDLE  | line released, waiting for an acceptable start
// SDEL  | 14 half-bit master/slave start delimiter
// DATA  | frame_words words, MSB first, popped on their first half-bit
// CRC   | 8-bit CRC (poly 0x07) of all data bits
// EDEL  | two low half-bits with the driver still enabled
// GAP   | driver off for GAP_BITS bit times, then done
module mvb_frame_tx #(
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int HALF_BIT_DIV = 8,
  parameter int MAX_WORDS    = 16,
  parameter int GAP_BITS     = 4
) (
  input  logic                          clk_24M,
  input  logic                          RESET,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          start,
  input  logic                          frame_type,
  input  logic [$clog2(MAX_WORDS):0]    frame_words,
  output logic                          busy,
  output logic                          done,
  output logic                          start_err,
  output logic                          tx_en,
  output logic                          data_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int FW   = $clog2(MAX_WORDS) + 1;
  localparam int TW   = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
  localparam int HMAX = (DATA_W > GAP_BITS) ? 2 * DATA_W : 2 * GAP_BITS;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [13:0] SDEL_MASTER = 14'b10111101000001;
  localparam logic [13:0] SDEL_SLAVE  = 14'b10101000110011;

  typedef enum logic [2:0] {S_IDLE, S_SDEL, S_DATA, S_CRC, S_EDEL, S_GAP} state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push, w_pop, w_full, w_accept_ok;
  logic [DATA_W-1:0] w_head;
  logic [13:0]       w_pat_sel;

  state_t            r_state, w_state_nx;
  logic [TW-1:0]     r_tmr, w_tmr_nx;
  logic [HW-1:0]     r_hidx, w_hidx_nx;
  logic [13:0]       r_pat, w_pat_nx;
  logic [DATA_W-1:0] r_shreg, w_shreg_nx;
  logic [7:0]        r_crc, w_crc_nx;
  logic [FW-1:0]     r_wleft, w_wleft_nx;
  logic              r_tx_en, w_tx_en_nx, r_data_out, w_dout_nx;
  logic              r_busy, w_busy_nx, r_done, w_done_nx, r_err, w_err_nx;
  logic              w_adv;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_in}} & 8'h07);
  endfunction

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = wr_en && !w_full;
  assign w_head      = r_mem[r_rptr];
  assign w_pat_sel   = frame_type ? SDEL_MASTER : SDEL_SLAVE;
  assign w_adv       = (r_tmr == '0);
  assign w_accept_ok = (frame_words != '0) && (32'(frame_words) <= 32'(MAX_WORDS)) &&
                       (32'(r_count) >= 32'(frame_words));

  always_ff @(posedge clk_24M) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk_24M) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = w_adv ? TW'(HALF_BIT_DIV - 1) : r_tmr - TW'(1);
    w_hidx_nx  = w_adv ? r_hidx + HW'(1) : r_hidx;
    w_pat_nx   = r_pat;
    w_shreg_nx = r_shreg;
    w_crc_nx   = r_crc;
    w_wleft_nx = r_wleft;
    w_tx_en_nx = r_tx_en;
    w_dout_nx  = r_data_out;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr_nx  = TW'(HALF_BIT_DIV - 1);
        w_hidx_nx = '0;
        if (start) begin
          if (w_accept_ok) begin
            w_state_nx = S_SDEL;
            w_tx_en_nx = 1'b1;
            w_busy_nx  = 1'b1;
            w_crc_nx   = '0;
            w_wleft_nx = frame_words;
            w_dout_nx  = w_pat_sel[13];
            w_pat_nx   = {w_pat_sel[12:0], 1'b0};
          end else begin
            w_err_nx = 1'b1;
          end
        end
      end
      S_SDEL: begin
        if (w_adv) begin
          if (r_hidx == HW'(13)) begin
            w_state_nx = S_DATA;
            w_hidx_nx  = '0;
            w_pop      = 1'b1;
            w_shreg_nx = w_head;
            w_dout_nx  = w_head[DATA_W-1];
            w_crc_nx   = crc8_step(r_crc, w_head[DATA_W-1]);
          end else begin
            w_dout_nx = r_pat[13];
            w_pat_nx  = {r_pat[12:0], 1'b0};
          end
        end
      end
      S_DATA: begin
        if (w_adv) begin
          if (r_hidx == HW'(2 * DATA_W - 1)) begin
            w_wleft_nx = r_wleft - FW'(1);
            w_hidx_nx  = '0;
            if (r_wleft == FW'(1)) begin
              w_state_nx = S_CRC;
              w_dout_nx  = r_crc[7];
            end else begin
              w_pop      = 1'b1;
              w_shreg_nx = w_head;
              w_dout_nx  = w_head[DATA_W-1];
              w_crc_nx   = crc8_step(r_crc, w_head[DATA_W-1]);
            end
          end else if (!r_hidx[0]) begin
            w_dout_nx = ~r_shreg[DATA_W-1];
          end else begin
            // Next bit moves to the MSB; it also feeds the CRC as it starts.
            w_shreg_nx = {r_shreg[DATA_W-2:0], 1'b0};
            w_dout_nx  = r_shreg[DATA_W-2];
            w_crc_nx   = crc8_step(r_crc, r_shreg[DATA_W-2]);
          end
        end
      end
      S_CRC: begin
        if (w_adv) begin
          if (r_hidx == HW'(15)) begin
            w_state_nx = S_EDEL;
            w_hidx_nx  = '0;
            w_dout_nx  = 1'b0;
          end else if (!r_hidx[0]) begin
            w_dout_nx = ~r_crc[7];
          end else begin
            w_crc_nx  = {r_crc[6:0], 1'b0};
            w_dout_nx = r_crc[6];
          end
        end
      end
      S_EDEL: begin
        if (w_adv && r_hidx == HW'(1)) begin
          w_state_nx = S_GAP;
          w_hidx_nx  = '0;
          w_tx_en_nx = 1'b0;
          w_dout_nx  = 1'b0;
        end
      end
      S_GAP: begin
        if (w_adv && r_hidx == HW'(2 * GAP_BITS - 1)) begin
          w_state_nx = S_IDLE;
          w_hidx_nx  = '0;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_24M) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_hidx     <= '0;
      r_pat      <= '0;
      r_shreg    <= '0;
      r_crc      <= '0;
      r_wleft    <= '0;
      r_tx_en    <= 1'b0;
      r_data_out <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tmr      <= w_tmr_nx;
      r_hidx     <= w_hidx_nx;
      r_pat      <= w_pat_nx;
      r_shreg    <= w_shreg_nx;
      r_crc      <= w_crc_nx;
      r_wleft    <= w_wleft_nx;
      r_tx_en    <= w_tx_en_nx;
      r_data_out <= w_dout_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
    end
  end

  assign full       = w_full;
  assign fifo_count = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign start_err  = r_err;
  assign tx_en      = r_tx_en;
  assign data_out   = r_data_out;

endmodule
